// File: rtl/diff_demo_pkg.sv
// rtl/diff_demo_pkg.sv - shared types and defaults for the feature-map loop-nest controller
package diff_demo_pkg;

    localparam int FM_CNT_W    = 8;
    localparam int CONF_PE_ROW = 4;
    localparam int CONF_PE_COL = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fm_loop_state_e;

    typedef struct packed {
        logic [FM_CNT_W-1:0] w_num;
        logic [FM_CNT_W-1:0] h_num;
        logic [FM_CNT_W-1:0] c_num;
        logic [FM_CNT_W-1:0] co_num;
        logic                kernel_mode;
        logic                is_diff;
        logic                is_first;
    } fm_loop_cfg_t;

endpackage

// File: rtl/fm_tile_loop_ctrl_row_tag.sv
// rtl/fm_tile_loop_ctrl_row_tag.sv - row parity, row-pair parity and mod-N row index tags
module fm_row_tag_gen #(
    parameter int ROW_MOD = 3,
    parameter int RM_W    = $clog2(ROW_MOD)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            inc,
    input  logic            kernel_mode,
    output logic            is_even_row,
    output logic            is_even_even_row,
    output logic [RM_W-1:0] row_mod
);

    logic            rm_adv;
    logic [RM_W-1:0] rm_next;

    // Large kernels span two physical rows per logical row-mod slot.
    assign rm_adv  = !kernel_mode || is_even_row;
    assign rm_next = (row_mod == RM_W'(ROW_MOD - 1)) ? '0 : row_mod + RM_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_even_row      <= 1'b0;
            is_even_even_row <= 1'b0;
            row_mod          <= '0;
        end else if (clear) begin
            is_even_row      <= 1'b0;
            is_even_even_row <= 1'b0;
            row_mod          <= '0;
        end else if (inc) begin
            is_even_row <= !is_even_row;
            if (is_even_row) begin
                is_even_even_row <= !is_even_even_row;
            end
            if (rm_adv) begin
                row_mod <= rm_next;
            end
        end
    end

endmodule

// File: rtl/fm_tile_loop_ctrl.sv
// rtl/fm_tile_loop_ctrl.sv - four-level w/h/c/co loop-nest walker with optional bit-mode second pass
module fm_tile_loop_ctrl
    import diff_demo_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int PE_ROW   = CONF_PE_ROW,
    parameter int PE_COL   = CONF_PE_COL,
    parameter int W_STEP_S = 6,
    parameter int W_STEP_L = 12,
    parameter int ROW_MOD  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [CNT_W-1:0]           w_num_i,
    input  logic [CNT_W-1:0]           h_num_i,
    input  logic [CNT_W-1:0]           c_num_i,
    input  logic [CNT_W-1:0]           co_num_i,
    input  logic                       kernel_mode_i,
    input  logic                       is_diff_i,
    input  logic                       is_first_i,
    input  logic                       abort,
    output logic                       step_valid,
    input  logic                       step_ready,
    output logic [CNT_W-1:0]           count_w,
    output logic [CNT_W-1:0]           count_h,
    output logic [CNT_W-1:0]           count_c,
    output logic [CNT_W-1:0]           count_co,
    output logic                       pass,
    output logic                       bit_mode,
    output logic                       is_even_row,
    output logic                       is_even_even_row,
    output logic [$clog2(ROW_MOD)-1:0] row_mod,
    output logic                       kernel_mode,
    output logic                       is_diff,
    output logic                       is_first,
    output logic                       last_step,
    output logic                       done,
    output logic                       cfg_err
);

    fm_loop_state_e state, state_nx;

    logic [CNT_W-1:0] w_max, h_max, c_max, co_max;
    logic [CNT_W-1:0] ws, cs;
    logic             accept, zero_cfg, fire, kill;
    logic             we, he, ce, coe, final_step;
    logic             row_inc, row_clr;

    assign accept   = cfg_valid && cfg_ready;
    assign zero_cfg = (w_num_i == '0) || (h_num_i == '0) || (c_num_i == '0) || (co_num_i == '0);
    assign kill     = abort && (state != IDLE);
    assign fire     = (state == RUN) && step_ready && !abort;

    assign bit_mode = is_diff && pass;
    assign ws       = kernel_mode ? CNT_W'(W_STEP_L) : CNT_W'(W_STEP_S);
    assign cs       = bit_mode ? CNT_W'(2 * PE_COL) : CNT_W'(PE_COL);

    // Compare against the stride before subtracting so no counter can wrap.
    assign we         = count_w < ws;
    assign he         = we && (count_h == '0);
    assign ce         = he && (count_c < cs);
    assign coe        = ce && (count_co < CNT_W'(PE_ROW));
    assign final_step = coe && (!is_diff || pass);
    assign last_step  = (state == RUN) && final_step;

    assign row_inc = fire && we && !he;
    assign row_clr = accept || kill || (fire && he && !final_step);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = zero_cfg ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (fire && final_step) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready  = (state == IDLE);
        step_valid = (state == RUN);
        done       = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_max       <= '0;
            h_max       <= '0;
            c_max       <= '0;
            co_max      <= '0;
            count_w     <= '0;
            count_h     <= '0;
            count_c     <= '0;
            count_co    <= '0;
            pass        <= 1'b0;
            kernel_mode <= 1'b0;
            is_diff     <= 1'b0;
            is_first    <= 1'b0;
            cfg_err     <= 1'b0;
        end else if (kill) begin
            count_w  <= '0;
            count_h  <= '0;
            count_c  <= '0;
            count_co <= '0;
            pass     <= 1'b0;
        end else if (accept) begin
            w_max       <= w_num_i - CNT_W'(1);
            h_max       <= h_num_i - CNT_W'(1);
            c_max       <= c_num_i - CNT_W'(1);
            co_max      <= co_num_i - CNT_W'(1);
            count_w     <= w_num_i - CNT_W'(1);
            count_h     <= h_num_i - CNT_W'(1);
            count_c     <= c_num_i - CNT_W'(1);
            count_co    <= co_num_i - CNT_W'(1);
            pass        <= 1'b0;
            kernel_mode <= kernel_mode_i;
            is_diff     <= is_diff_i;
            is_first    <= is_first_i;
            cfg_err     <= zero_cfg;
        end else if (fire) begin
            if (!we) begin
                count_w <= count_w - ws;
            end else if (!he) begin
                count_w <= w_max;
                count_h <= count_h - CNT_W'(1);
            end else if (!ce) begin
                count_w <= w_max;
                count_h <= h_max;
                count_c <= count_c - cs;
            end else if (!coe) begin
                count_w  <= w_max;
                count_h  <= h_max;
                count_c  <= c_max;
                count_co <= count_co - CNT_W'(PE_ROW);
            end else if (is_diff && !pass) begin
                // Second pass re-walks the whole nest in bit-mode.
                pass     <= 1'b1;
                count_w  <= w_max;
                count_h  <= h_max;
                count_c  <= c_max;
                count_co <= co_max;
            end
        end
    end

    fm_row_tag_gen #(
        .ROW_MOD (ROW_MOD)
    ) u_row_tag (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear            (row_clr),
        .inc              (row_inc),
        .kernel_mode      (kernel_mode),
        .is_even_row      (is_even_row),
        .is_even_even_row (is_even_even_row),
        .row_mod          (row_mod)
    );

endmodule
